// File: rtl/sd_dat_block_rx.sv
// sd_dat_block_rx: 4-bit SD data-block receiver (card-to-host read direction).
//   Generates sd_clk from clk, waits for the start bit on all four DAT lines,
//   deserialises BLOCK_BYTES bytes into a byte FIFO, then checks the per-line
//   CRC16-CCITT and the end bit. The CPU drains the FIFO over an Avalon-MM
//   slave with read latency 1.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address, chipselect, read_n, write_n, writedata, readdata
//                       register port: 0 CTRL, 1 STATUS, 2 DATA (pop), 3 DIV
//   sd_clk              SD card clock, toggles every div+1 clk cycles when running
//   sd_dat              DAT[3:0] from the card, already synchronised
//   irq                 level interrupt, done | timeout
module sd_dat_block_rx #(
  parameter int         BLOCK_BYTES  = 512,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         TIMEOUT_CLKS = 4096,
  parameter logic [7:0] DIV_RESET    = 8'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  input  logic [3:0]  sd_dat,
  output logic        irq
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W_FIFO = PTR_W + 1;
  localparam int DATA_EDGES = BLOCK_BYTES * 2;
  localparam int CNT_MAX    = (TIMEOUT_CLKS > DATA_EDGES) ? TIMEOUT_CLKS : DATA_EDGES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              div, div_cnt;
  logic [CNT_W-1:0]        cnt;
  logic                    nib;          // 0: next DATA edge carries byte[7:4]
  logic [3:0]              hi_nib;
  logic [3:0][15:0]        crc;
  logic                    done, crc_err, timeout;
  logic [7:0]              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W_FIFO-1:0]   count;
  logic [31:0]             rd_mux;
  logic                    unused_ok;

  wire wr        = chipselect & ~write_n;
  wire rd        = chipselect & ~read_n;
  wire ctrl_wr   = wr && (address == 2'd0);
  wire abort_cmd = ctrl_wr & writedata[1];
  wire launch    = ctrl_wr & writedata[0] & ~abort_cmd & (state == S_IDLE);
  wire busy      = (state != S_IDLE);
  wire fifo_full = (count == CNT_W_FIFO'(FIFO_DEPTH));

  // Stall only at a byte boundary, so the byte being assembled always has a
  // free slot by the time its second nibble arrives.
  wire stall  = (state == S_DATA) && fifo_full && !nib;
  // A high sd_clk is allowed to finish its half period before the stall holds it low.
  wire run    = busy && !(stall && !sd_clk);
  wire tick   = run && (div_cnt >= div);
  wire sd_rise = tick && !sd_clk && !abort_cmd;

  wire       push  = sd_rise && (state == S_DATA) && nib;
  wire       flush = abort_cmd | launch;
  wire       pop   = rd && (address == 2'd2) && (count != '0);

  assign irq       = done | timeout;
  assign unused_ok = ^writedata[31:8];

  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (launch) state_nxt = S_WAIT_START;
      S_WAIT_START: if (sd_rise) begin
                      if (sd_dat == 4'b0000)                     state_nxt = S_DATA;
                      else if (cnt == CNT_W'(TIMEOUT_CLKS - 1))  state_nxt = S_IDLE;
                    end
      S_DATA:       if (sd_rise && cnt == CNT_W'(DATA_EDGES - 1)) state_nxt = S_CRC;
      S_CRC:        if (sd_rise && cnt == CNT_W'(15))             state_nxt = S_END;
      S_END:        if (sd_rise)                                   state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
    if (abort_cmd) state_nxt = S_IDLE;
  end

  // SD clock generator and divider register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div     <= DIV_RESET;
      div_cnt <= '0;
      sd_clk  <= 1'b0;
    end else begin
      if (wr && address == 2'd3) div <= writedata[7:0];
      if (abort_cmd || !run) begin
        sd_clk  <= 1'b0;
        div_cnt <= '0;
      end else if (tick) begin
        sd_clk  <= ~sd_clk;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Deserialiser, CRC engines and flags; everything advances on sd_clk rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0; nib <= 1'b0; hi_nib <= '0; crc <= '0;
      done <= 1'b0; crc_err <= 1'b0; timeout <= 1'b0;
    end else if (flush) begin
      cnt <= '0; nib <= 1'b0; crc <= '0;
      done <= 1'b0; crc_err <= 1'b0; timeout <= 1'b0;
    end else if (sd_rise) begin
      case (state)
        S_WAIT_START: begin
          if (sd_dat == 4'b0000)                    cnt <= '0;
          else if (cnt == CNT_W'(TIMEOUT_CLKS - 1)) timeout <= 1'b1;
          else                                      cnt <= cnt + 1'b1;
        end
        S_DATA: begin
          for (int i = 0; i < 4; i++) crc[i] <= crc_next(crc[i], sd_dat[i]);
          if (!nib) hi_nib <= sd_dat;
          nib <= ~nib;
          cnt <= (cnt == CNT_W'(DATA_EDGES - 1)) ? '0 : cnt + 1'b1;
        end
        S_CRC: begin
          for (int i = 0; i < 4; i++) begin
            if (sd_dat[i] != crc[i][15]) crc_err <= 1'b1;
            crc[i] <= {crc[i][14:0], 1'b0};
          end
          cnt <= (cnt == CNT_W'(15)) ? '0 : cnt + 1'b1;
        end
        S_END: begin
          if (sd_dat != 4'hF) crc_err <= 1'b1;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Receive FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0;
    end else if (flush) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by count, and
  // an empty FIFO never exposes mem contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {hi_nib, sd_dat};
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd1: begin
        rd_mux[0]    = busy;
        rd_mux[1]    = done;
        rd_mux[2]    = crc_err;
        rd_mux[3]    = timeout;
        rd_mux[4]    = (count != '0);
        rd_mux[12:8] = 5'(count);
      end
      2'd2:    rd_mux[7:0] = (count != '0) ? mem[rd_ptr] : 8'h00;
      2'd3:    rd_mux[7:0] = div;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// tb_sd_dat_block_rx: scoreboard bench for sd_dat_block_rx.
//   A card model drives DAT nibbles on falling sd_clk edges; the expected
//   payload is queued when a block is launched and a monitor pops and compares
//   on every DATA register read.
module tb_sd_dat_block_rx;

  localparam int BLOCK_BYTES = 512;
  localparam int DATA_N      = BLOCK_BYTES * 2;
  localparam int STREAM_N    = DATA_N + 17;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        sd_clk;
  logic [3:0]  sd_dat = 4'hF;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb_q [$];
  logic [3:0] nib_stream [STREAM_N];
  logic       card_stop = 1'b0;
  logic       card_busy = 1'b0;

  sd_dat_block_rx dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sd_clk(sd_clk), .sd_dat(sd_dat), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: every DATA read is compared against the head of the scoreboard.
  initial forever begin
    @(posedge clk); #1;
    if (reset_n && chipselect && !read_n && address == 2'd2) begin
      if (sb_q.size() == 0) bound_fail("data_read_without_expectation");
      else check("data", readdata, {24'h0, sb_q.pop_front()});
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = c ^ {b, 15'h0};
    if (r[15]) r = (r << 1) ^ 16'h1021;
    else       r = r << 1;
    return r;
  endfunction

  // Payload byte k = k mod 256; CRC nibble j carries bit 15-j of each line's CRC.
  task automatic build_block(input bit flip_crc, input bit bad_end);
    logic [15:0] c [4];
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) c[i] = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      b = k[7:0];
      nib_stream[2*k]   = b[7:4];
      nib_stream[2*k+1] = b[3:0];
      for (int i = 0; i < 4; i++) begin
        c[i] = crc_bit(c[i], b[4+i]);
        c[i] = crc_bit(c[i], b[i]);
      end
    end
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 4; i++) nib_stream[DATA_N+j][i] = c[i][15-j];
    // CRC bit 5 goes out on the 11th CRC edge.
    if (flip_crc) nib_stream[DATA_N+10][2] = ~nib_stream[DATA_N+10][2];
    nib_stream[DATA_N+16] = bad_end ? 4'hE : 4'hF;
  endtask

  task automatic wait_fall(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (!card_stop && sd_clk !== 1'b1 && n < 5000) begin @(posedge clk); #2; n++; end
    while (!card_stop && sd_clk !== 1'b0 && n < 5000) begin @(posedge clk); #2; n++; end
    if (card_stop) return;
    if (n >= 5000) begin
      bound_fail("card_sd_clk");
      card_stop = 1'b1;
    end else ok = 1'b1;
  endtask

  task automatic send_block();
    bit ok;
    card_busy = 1'b1;
    sd_dat = 4'hF;
    wait_fall(ok);
    if (ok) begin
      sd_dat = 4'h0;
      for (int j = 0; j < STREAM_N; j++) begin
        wait_fall(ok);
        if (!ok) break;
        sd_dat = nib_stream[j];
      end
      if (ok) wait_fall(ok);
    end
    sd_dat = 4'hF;
    card_busy = 1'b0;
  endtask

  task automatic wait_card();
    int n;
    n = 0;
    while (card_busy && n < 200) begin @(posedge clk); n++; end
    if (card_busy) bound_fail("card_finish");
    card_stop = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  // Poll STATUS and pop whenever non-empty; stop at max_bytes or when idle and empty.
  task automatic drain(input int max_bytes, output int got);
    logic [31:0] st, d;
    int guard;
    got = 0;
    guard = 0;
    forever begin
      bus_rd(2'd1, st);
      if (st[4]) begin
        bus_rd(2'd2, d);
        got++;
        if (got == max_bytes) break;
      end else if (!st[0]) break;
      guard++;
      if (guard > 10000) begin bound_fail("drain"); break; end
    end
  endtask

  task automatic count_high(input int cycles, output int highs);
    highs = 0;
    repeat (cycles) begin @(posedge clk); #1; if (sd_clk) highs++; end
  endtask

  task automatic measure_period(output int per);
    int n;
    bit seen_low;
    n = 0; per = 0; seen_low = 1'b0;
    while (sd_clk !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    while (n < 200) begin
      @(posedge clk); #1; n++; per++;
      if (!sd_clk) seen_low = 1'b1;
      else if (seen_low) break;
    end
  endtask

  task automatic launch_block(input bit flip, input bit bad_end);
    build_block(flip, bad_end);
    sb_q.delete();
    for (int k = 0; k < BLOCK_BYTES; k++) sb_q.push_back(8'(k));
    fork
      send_block();
    join_none
    bus_wr(2'd0, 32'h1);
  endtask

  task automatic run_block(input string tag, input bit flip, input bit bad_end,
                           input bit restart_mid, input logic [31:0] exp_status);
    int per, got, got2;
    logic [31:0] st;
    launch_block(flip, bad_end);
    measure_period(per);
    check({tag, "_sd_clk_period"}, per, 4);
    got2 = 0;
    if (restart_mid) begin
      drain(100, got);
      bus_wr(2'd0, 32'h1);  // START while busy must not disturb the block
      drain(-1, got2);
    end else drain(-1, got);
    check({tag, "_bytes"}, got + got2, BLOCK_BYTES);
    bus_rd(2'd1, st);
    check({tag, "_status"}, st, exp_status);
    check({tag, "_irq"}, irq, 1'b1);
    check({tag, "_scoreboard_empty"}, sb_q.size(), 0);
    wait_card();
  endtask

  initial begin
    logic [31:0] d, st;
    int got, highs, n, edges;
    logic prev;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sd_clk", sd_clk, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_readdata", readdata, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    bus_rd(2'd1, d); check("rst_status", d, 32'h0);
    bus_rd(2'd3, d); check("rst_div", d, 32'h4);
    bus_rd(2'd0, d); check("ctrl_reads_zero", d, 32'h0);
    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus_rd(2'd1, d); check("status_write_ignored", d, 32'h0);
    sb_q.push_back(8'h00);
    bus_rd(2'd2, d);  // empty pop: monitor expects 0

    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3, d); check("div_write", d, 32'h1);

    run_block("good", 1'b0, 1'b0, 1'b1, 32'h2);
    run_block("crc_flip", 1'b1, 1'b0, 1'b0, 32'h6);
    run_block("bad_end", 1'b0, 1'b1, 1'b0, 32'h6);

    // FIFO-full stall: no reads until the FIFO holds 16 bytes.
    launch_block(1'b0, 1'b0);
    n = 0;
    do begin bus_rd(2'd1, st); n++; end while (st[12:8] != 5'd16 && n < 3000);
    check("stall_status_full", st, 32'h1011);
    repeat (4) @(posedge clk);
    count_high(40, highs);
    check("stall_sd_clk_low", highs, 0);
    bus_rd(2'd1, st); check("stall_count_held", st, 32'h1011);
    bus_rd(2'd2, d);
    n = 0;
    while (sd_clk !== 1'b1 && n < 2) begin @(posedge clk); #1; n++; end
    check("stall_resume", sd_clk, 1'b1);
    drain(-1, got);
    check("stall_rest_bytes", got, BLOCK_BYTES - 1);
    bus_rd(2'd1, st); check("stall_status_done", st, 32'h2);
    check("stall_scoreboard_empty", sb_q.size(), 0);
    wait_card();

    // ABORT together with START at byte 100.
    launch_block(1'b0, 1'b0);
    drain(100, got);
    check("abort_bytes_before", got, 100);
    card_stop = 1'b1;
    bus_wr(2'd0, 32'h3);
    check("abort_sd_clk", sd_clk, 1'b0);
    bus_rd(2'd1, st); check("abort_status", st, 32'h0);
    check("abort_irq", irq, 1'b0);
    sb_q.delete();
    sb_q.push_back(8'h00);
    bus_rd(2'd2, d);
    count_high(20, highs);
    check("abort_sd_clk_idle", highs, 0);
    wait_card();

    // Start-bit timeout with DAT held high.
    sd_dat = 4'hF;
    bus_wr(2'd3, 32'h0);
    bus_wr(2'd0, 32'h1);
    edges = 0; n = 0; prev = sd_clk;
    while (!irq && n < 20000) begin
      @(posedge clk); #1; n++;
      if (sd_clk && !prev) edges++;
      prev = sd_clk;
    end
    check("timeout_edges", edges, 4096);
    bus_rd(2'd1, st); check("timeout_status", st, 32'h8);
    check("timeout_irq", irq, 1'b1);
    count_high(20, highs);
    check("timeout_sd_clk_idle", highs, 0);

    // Reset in the middle of a block.
    bus_wr(2'd3, 32'h1);
    launch_block(1'b0, 1'b0);
    drain(20, got);
    check("reset_mid_bytes_before", got, 20);
    @(negedge clk);
    #2 reset_n = 1'b0;
    card_stop = 1'b1;
    #1 check("reset_async_sd_clk", sd_clk, 1'b0);
    @(posedge clk); #1;
    check("reset_sd_clk", sd_clk, 1'b0);
    check("reset_readdata", readdata, 32'h0);
    sb_q.delete();
    @(negedge clk) reset_n = 1'b1;
    bus_rd(2'd1, d); check("reset_status", d, 32'h0);
    bus_rd(2'd3, d); check("reset_div", d, 32'h4);
    wait_card();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
